seq_shift_add_multiplier: RTL and testbench

//  Parametrised sequential unsigned multiplier, next generation of the full/half adder blocks.

---
 rtl/seq_shift_add_multiplier_pkg.sv | 23 ++
 rtl/seq_shift_add_multiplier_rca_adder.sv | 45 ++++
 rtl/seq_shift_add_multiplier.sv | 157 +++++++++++++++
 tb/tb_seq_shift_add_multiplier.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
// The FSM encoding is exported both as an enum and as plain localparams.
package mult_pkg;

  localparam int unsigned MULT_MAX_WIDTH = 32;
  localparam int unsigned STATE_W        = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Step counter width: enough to hold WIDTH-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_rca_adder.sv
// Ripple-carry adder built from full_adder cells, carry passed
// between generate scopes as scalars.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

module rca_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic c_out;
    logic c_in;
    if (i == 0) begin : g_first
      assign c_in = cin_i;
    end else begin : g_rest
      assign c_in = g_bit[i-1].c_out;
    end
    full_adder u_fa (
      .a_i   (a_i[i]),
      .b_i   (b_i[i]),
      .cin_i (c_in),
      .sum_o (sum_o[i]),
      .cout_o(c_out)
    );
  end

  assign cout_o = g_bit[WIDTH-1].c_out;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Radix-2 sequential multiplier: one partial product per clock, start/done handshake.
// Define MULT_SIGNED_EN for two's-complement operands and product.
module seq_shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CNT_W  = cnt_width(WIDTH);
  localparam int unsigned PROD_W = 2 * WIDTH;

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [PROD_W-1:0]  product_q, product_d;

  logic               last_step_c;
  logic [WIDTH-1:0]   addend_c;
  logic               cin_c;
  logic [WIDTH-1:0]   add_sum_c;
  logic               add_cout_c;
  logic               sum_top_c;
  logic               shift_fill_c;
  logic [WIDTH:0]     acc_step_c;
  logic [WIDTH-1:0]   mplier_step_c;

  assign last_step_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Adder operand select; the signed final step subtracts the multiplicand.
  always_comb begin
    addend_c = '0;
    cin_c    = 1'b0;
    if (mplier_q[0]) begin
`ifdef MULT_SIGNED_EN
      if (last_step_c) begin
        addend_c = ~mcand_q;
        cin_c    = 1'b1;
      end else begin
        addend_c = mcand_q;
      end
`else
      addend_c = mcand_q;
`endif
    end
  end

  rca_adder #(.WIDTH(WIDTH)) u_rca (
    .a_i   (acc_q[WIDTH-1:0]),
    .b_i   (addend_c),
    .cin_i (cin_c),
    .sum_o (add_sum_c),
    .cout_o(add_cout_c)
  );

  // Bit WIDTH of the (WIDTH+1)-bit partial sum, extending each operand.
`ifdef MULT_SIGNED_EN
  assign sum_top_c    = acc_q[WIDTH] ^ addend_c[WIDTH-1] ^ add_cout_c;
  assign shift_fill_c = sum_top_c;
`else
  assign sum_top_c    = acc_q[WIDTH] ^ add_cout_c;
  assign shift_fill_c = 1'b0;
`endif

  assign acc_step_c    = {shift_fill_c, sum_top_c, add_sum_c[WIDTH-1:1]};
  assign mplier_step_c = {add_sum_c[0], mplier_q[WIDTH-1:1]};

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    product_d = product_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d    = acc_step_c;
        mplier_d = mplier_step_c;
        if (last_step_c) begin
          product_d = {acc_step_c[WIDTH-1:0], mplier_step_c};
          done_d    = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          mcand_d  = a;
          mplier_d = b;
          acc_d    = '0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier at WIDTH=8; expected
// products are queued at start and matched against observed done pulses.
module tb_seq_shift_add_multiplier;

  localparam int W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] got_q[$];
  int             got_cyc[$];
  int             cyc;
  int             busy_cnt;
  int             n_checks;
  int             n_pass;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every done pulse and count busy cycles.
  initial busy_cnt = 0;
  always @(negedge clk) begin
    if (done === 1'b1) begin
      got_q.push_back(product);
      got_cyc.push_back(cyc);
    end
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
  end

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef MULT_SIGNED_EN
    return 16'($signed(x) * $signed(y));
`else
    return 16'(x) * 16'(y);
`endif
  endfunction

  // Called at a negedge; returns the cycle index of the accepting edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, output int acc_c);
    a     = x;
    b     = y;
    start = 1'b1;
    exp_q.push_back(model(x, y));
    @(negedge clk);
    start = 1'b0;
    acc_c = cyc;
  endtask

  task automatic flush_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (product !== 16'h0000) $display("FAIL reset_product got=%h exp=0000", product); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int acc_c, busy0;
    logic [2*W-1:0] g, e;
    busy0 = busy_cnt;
    start_op(8'd13, 8'd11, acc_c);
    repeat (W + 4) @(negedge clk);
    n_checks++; if (busy_cnt - busy0 !== W) $display("FAIL basic_busy_cycles got=%0d exp=%0d", busy_cnt - busy0, W); else n_pass++;
    n_checks++; if (got_q.size() !== 1) $display("FAIL basic_done_count got=%0d exp=1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1 && exp_q.size() >= 1) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e || g !== 16'h008F) $display("FAIL basic_product got=%h exp=008f", g); else n_pass++;
      n_checks++; if (got_cyc[0] - acc_c !== W) $display("FAIL basic_latency got=%0d exp=%0d", got_cyc[0] - acc_c, W); else n_pass++;
    end
    n_checks++; if (product !== 16'h008F) $display("FAIL basic_product_held got=%h exp=008f", product); else n_pass++;
    flush_sb();
  endtask

  task automatic test_extremes();
    int acc_c;
    logic [2*W-1:0] g, e;
    start_op(8'd255, 8'd255, acc_c);
    repeat (W + 3) @(negedge clk);
    start_op(8'd0, 8'd200, acc_c);
    repeat (W + 3) @(negedge clk);
    n_checks++; if (got_q.size() !== 2) $display("FAIL ext_done_count got=%0d exp=2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2 && exp_q.size() >= 2) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
`ifdef MULT_SIGNED_EN
      n_checks++; if (g !== e || g !== 16'h0001) $display("FAIL ext_max got=%h exp=0001", g); else n_pass++;
`else
      n_checks++; if (g !== e || g !== 16'hFE01) $display("FAIL ext_max got=%h exp=fe01", g); else n_pass++;
`endif
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e || g !== 16'h0000) $display("FAIL ext_zero got=%h exp=0000", g); else n_pass++;
      n_checks++; if (got_cyc[1] - acc_c !== W) $display("FAIL ext_zero_latency got=%0d exp=%0d", got_cyc[1] - acc_c, W); else n_pass++;
    end
    flush_sb();
  endtask

  task automatic test_ignore_busy();
    int acc_c;
    logic [2*W-1:0] g, e;
    start_op(8'd5, 8'd6, acc_c);
    repeat (3) @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W + 6) @(negedge clk);
    n_checks++; if (got_q.size() !== 1) $display("FAIL ignore_done_count got=%0d exp=1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1 && exp_q.size() >= 1) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e || g !== 16'd30) $display("FAIL ignore_product got=%0d exp=30", g); else n_pass++;
    end
    flush_sb();
  endtask

  task automatic test_back_to_back();
    int acc_c;
    logic [2*W-1:0] g, e;
    a = 8'd7; b = 8'd9; start = 1'b1;
    exp_q.push_back(model(8'd7, 8'd9));
    @(negedge clk);
    acc_c = cyc;
    repeat (W) @(negedge clk);
    // DONE cycle: still requesting, with the second operand pair
    a = 8'd6; b = 8'd6;
    exp_q.push_back(model(8'd6, 8'd6));
    @(negedge clk);
    start = 1'b0;
    repeat (W + 4) @(negedge clk);
    n_checks++; if (got_q.size() !== 2) $display("FAIL b2b_done_count got=%0d exp=2", got_q.size()); else n_pass++;
    if (got_q.size() >= 2 && exp_q.size() >= 2) begin
      n_checks++; if (got_cyc[0] - acc_c !== W) $display("FAIL b2b_latency got=%0d exp=%0d", got_cyc[0] - acc_c, W); else n_pass++;
      n_checks++; if (got_cyc[1] - got_cyc[0] !== W + 1) $display("FAIL b2b_spacing got=%0d exp=%0d", got_cyc[1] - got_cyc[0], W + 1); else n_pass++;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e || g !== 16'd63) $display("FAIL b2b_first got=%0d exp=63", g); else n_pass++;
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e || g !== 16'd36) $display("FAIL b2b_second got=%0d exp=36", g); else n_pass++;
    end
    flush_sb();
  endtask

  task automatic test_reset_mid_run();
    int acc_c;
    logic [2*W-1:0] g, e;
    start_op(8'd100, 8'd200, acc_c);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy got=%b exp=0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL abort_done got=%b exp=0", done); else n_pass++;
    n_checks++; if (product !== 16'h0000) $display("FAIL abort_product got=%h exp=0000", product); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    n_checks++; if (got_q.size() !== 0) $display("FAIL abort_no_done got=%0d exp=0", got_q.size()); else n_pass++;
    flush_sb();
    start_op(8'd3, 8'd3, acc_c);
    repeat (W + 3) @(negedge clk);
    n_checks++; if (got_q.size() !== 1) $display("FAIL abort_next_count got=%0d exp=1", got_q.size()); else n_pass++;
    if (got_q.size() >= 1 && exp_q.size() >= 1) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      n_checks++; if (g !== e || g !== 16'd9) $display("FAIL abort_next_product got=%0d exp=9", g); else n_pass++;
    end
    flush_sb();
  endtask

  task automatic test_signed_table();
    int acc_c;
    logic [2*W-1:0] g;
    logic [2*W-1:0] req[3];
    logic [W-1:0]   ta[3];
    logic [W-1:0]   tb_[3];
    ta[0] = 8'hFD; tb_[0] = 8'd5;
    ta[1] = 8'h80; tb_[1] = 8'h80;
    ta[2] = 8'd127; tb_[2] = 8'hFF;
`ifdef MULT_SIGNED_EN
    req[0] = 16'hFFF1; req[1] = 16'h4000; req[2] = 16'hFF81;
`else
    req[0] = 16'd1265; req[1] = 16'h4000; req[2] = 16'd32385;
`endif
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb_[i], acc_c);
      repeat (W + 3) @(negedge clk);
      n_checks++;
      if (got_q.size() !== 1) begin
        $display("FAIL table%0d_count got=%0d exp=1", i, got_q.size());
      end else begin
        g = got_q.pop_front();
        if (g !== req[i]) $display("FAIL table%0d_product got=%h exp=%h", i, g, req[i]);
        else n_pass++;
      end
      flush_sb();
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_signed_table();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
